// File: rtl/gpio_master_pkg.sv
// Shared op-codes, FSM state encoding and helpers for the GPIO bus master.
package gpio_master_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_CLR   = 3'd3;
    localparam logic [2:0] OP_TGL   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    function automatic logic is_rmw(input logic [2:0] op);
        return (op == OP_SET) || (op == OP_CLR) || (op == OP_TGL);
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_TGL;
    endfunction

endpackage

// File: rtl/gpio_rmw_alu.sv
// Combinational write-data generator: plain write data or old value combined with a bit mask.
module gpio_rmw_alu
    import gpio_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] wdata_o
);

    always_comb begin
        wdata_o = data_i;
        case (op_i)
            OP_SET:  wdata_o = old_i | data_i;
            OP_CLR:  wdata_o = old_i & ~data_i;
            OP_TGL:  wdata_o = old_i ^ data_i;
            default: wdata_o = data_i;
        endcase
    end

endmodule

// File: rtl/gpio_bus_master.sv
// Single-outstanding command initiator for the GPIO register bank, with atomic SET/CLR/TGL.
module gpio_bus_master
    import gpio_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic              bus_wr_enable_o,
    output logic              bus_rd_enable_o,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] alu_wdata;
    logic              cmd_bad;

    assign cmd_bad = !is_legal_op(cmd_op_i) || (cmd_addr_i[1:0] != 2'b00);

    gpio_rmw_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i    (op_q),
        .old_i   (old_q),
        .data_i  (data_q),
        .wdata_o (alu_wdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_bad)                    state_d = ST_RSP;
                    else if (cmd_op_i == OP_WRITE)  state_d = ST_WR;
                    else                            state_d = ST_RD;
                end
            end
            ST_RD:   state_d = is_rmw(op_q) ? ST_WR : ST_RSP;
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // RD loads the read value into both old_q and the response, so RMW ops answer with the pre-modify value.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_q     <= '0;
            old_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q      <= cmd_op_i;
                        addr_q    <= cmd_addr_i;
                        data_q    <= cmd_data_i;
                        rsp_err_q <= cmd_bad;
                        if (cmd_bad) rsp_data_q <= '0;
                    end
                end
                ST_RD: begin
                    old_q      <= bus_rdata_i;
                    rsp_data_q <= bus_rdata_i;
                end
                ST_WR: begin
                    if (op_q == OP_WRITE) rsp_data_q <= data_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready_o     = 1'b0;
        rsp_valid_o     = 1'b0;
        bus_addr_o      = '0;
        bus_wdata_o     = '0;
        bus_wr_enable_o = 1'b0;
        bus_rd_enable_o = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready_o = 1'b1;
            ST_RD: begin
                bus_rd_enable_o = 1'b1;
                bus_addr_o      = addr_q;
            end
            ST_WR: begin
                bus_wr_enable_o = 1'b1;
                bus_addr_o      = addr_q;
                bus_wdata_o     = alu_wdata;
            end
            ST_RSP:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Directed bench for gpio_bus_master driving a behavioural four-register GPIO bank.
module tb_gpio_bus_master;

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_CLR   = 3'd3;
    localparam logic [2:0] OP_TGL   = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [63:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wr_enable;
    logic        bus_rd_enable;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;
    int rdCount = 0;
    int wrCount = 0;
    int overlapCount = 0;
    logic [63:0] lastWrAddr = '0;
    logic [31:0] lastWrData = '0;

    logic [31:0] gpioRegs [4];

    always #5 clk = ~clk;

    gpio_bus_master #(.ADDR_W(64), .DATA_W(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_op_i        (cmd_op),
        .cmd_addr_i      (cmd_addr),
        .cmd_data_i      (cmd_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data),
        .rsp_err_o       (rsp_err),
        .bus_addr_o      (bus_addr),
        .bus_wdata_o     (bus_wdata),
        .bus_wr_enable_o (bus_wr_enable),
        .bus_rd_enable_o (bus_rd_enable),
        .bus_rdata_i     (bus_rdata)
    );

    // GPIO bank: registered writes, combinational reads, no reset so contents survive a master reset.
    always @(posedge clk) begin
        if (bus_wr_enable) gpioRegs[bus_addr[3:2]] <= bus_wdata;
    end
    assign bus_rdata = bus_rd_enable ? gpioRegs[bus_addr[3:2]] : 32'h0;

    always @(negedge clk) begin
        if (bus_rd_enable) rdCount++;
        if (bus_wr_enable) begin
            wrCount++;
            lastWrAddr = bus_addr;
            lastWrData = bus_wdata;
        end
        if (bus_rd_enable && bus_wr_enable) overlapCount++;
    end

    // Issue one command from IDLE, wait for its response and complete the handshake.
    task automatic applyStimulus(input logic [2:0] op, input logic [63:0] addr, input logic [31:0] data,
                                 output logic [31:0] rdata, output logic err, output int lat,
                                 output int rdDelta, output int wrDelta);
        int rd0, wr0;
        rd0 = rdCount;
        wr0 = wrCount;
        rsp_ready = 1'b1;
        cmd_op = op;
        cmd_addr = addr;
        cmd_data = data;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_data;
        err = rsp_err;
        rdDelta = rdCount - rd0;
        wrDelta = wrCount - wr0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = OP_WRITE;
        cmd_addr = 64'h4;
        cmd_data = 32'h1234;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin
            failures++; $display("[TB] FAIL reset_rsp: got valid=%b err=%b data=%h expected 0/0/0", rsp_valid, rsp_err, rsp_data);
        end
        checks++;
        if (bus_rd_enable !== 1'b0 || bus_wr_enable !== 1'b0 || bus_addr !== 64'h0 || bus_wdata !== 32'h0) begin
            failures++; $display("[TB] FAIL reset_bus: got rd=%b wr=%b addr=%h wdata=%h expected all 0", bus_rd_enable, bus_wr_enable, bus_addr, bus_wdata);
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic e; int lat, rdd, wrd;
        applyStimulus(OP_WRITE, 64'h4, 32'hDEADBEEF, d, e, lat, rdd, wrd);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin failures++; $display("[TB] FAIL write_rsp: got data=%h err=%b expected deadbeef/0", d, e); end
        checks++;
        if (lat != 2) begin failures++; $display("[TB] FAIL write_latency: got %0d expected 2", lat); end
        checks++;
        if (wrd != 1 || rdd != 0 || lastWrAddr !== 64'h4 || lastWrData !== 32'hDEADBEEF) begin
            failures++; $display("[TB] FAIL write_bus: got wr=%0d rd=%0d addr=%h data=%h expected 1/0/4/deadbeef", wrd, rdd, lastWrAddr, lastWrData);
        end
        applyStimulus(OP_READ, 64'h4, 32'h0, d, e, lat, rdd, wrd);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0 || lat != 2) begin
            failures++; $display("[TB] FAIL read_back: got data=%h err=%b lat=%0d expected deadbeef/0/2", d, e, lat);
        end
        checks++;
        if (rdd != 1 || wrd != 0) begin failures++; $display("[TB] FAIL read_strobes: got rd=%0d wr=%0d expected 1/0", rdd, wrd); end
    endtask

    task automatic test_rmw();
        logic [2:0]  ops  [3] = '{OP_SET, OP_CLR, OP_TGL};
        logic [31:0] masks[3] = '{32'h0F, 32'h30, 32'hFF};
        logic [31:0] olds [3] = '{32'hF0, 32'hFF, 32'hCF};
        logic [31:0] news [3] = '{32'hFF, 32'hCF, 32'h30};
        logic [31:0] d; logic e; int lat, rdd, wrd;
        applyStimulus(OP_WRITE, 64'h4, 32'h000000F0, d, e, lat, rdd, wrd);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(ops[i], 64'h4, masks[i], d, e, lat, rdd, wrd);
            checks++;
            if (d !== olds[i] || e !== 1'b0) begin failures++; $display("[TB] FAIL rmw%0d_rsp: got data=%h err=%b expected %h/0", i, d, e, olds[i]); end
            checks++;
            if (gpioRegs[1] !== news[i]) begin failures++; $display("[TB] FAIL rmw%0d_reg: got %h expected %h", i, gpioRegs[1], news[i]); end
            checks++;
            if (lat != 3 || rdd != 1 || wrd != 1) begin
                failures++; $display("[TB] FAIL rmw%0d_timing: got lat=%0d rd=%0d wr=%0d expected 3/1/1", i, lat, rdd, wrd);
            end
        end
    endtask

    task automatic test_errors();
        logic [2:0]  ops  [2] = '{3'd6, OP_READ};
        logic [63:0] addrs[2] = '{64'h0, 64'h6};
        logic [31:0] d; logic e; int lat, rdd, wrd;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(ops[i], addrs[i], 32'hFFFFFFFF, d, e, lat, rdd, wrd);
            checks++;
            if (e !== 1'b1 || d !== 32'h0 || lat != 1) begin
                failures++; $display("[TB] FAIL err%0d_rsp: got err=%b data=%h lat=%0d expected 1/0/1", i, e, d, lat);
            end
            checks++;
            if (rdd != 0 || wrd != 0) begin failures++; $display("[TB] FAIL err%0d_strobes: got rd=%0d wr=%0d expected 0/0", i, rdd, wrd); end
        end
    endtask

    task automatic test_stall();
        int wr0, lat;
        rsp_ready = 1'b0;
        cmd_op = OP_READ; cmd_addr = 64'h4; cmd_data = 32'h0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        cmd_op = OP_WRITE; cmd_addr = 64'h8; cmd_data = 32'h00000BAD; cmd_valid = 1'b1;
        wr0 = wrCount;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h30 || cmd_ready !== 1'b0) begin
                failures++; $display("[TB] FAIL stall%0d: got valid=%b data=%h ready=%b expected 1/00000030/0", i, rsp_valid, rsp_data, cmd_ready);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (wrCount != wr0) begin failures++; $display("[TB] FAIL stall_ignored_cmd: got %0d writes expected 0", wrCount - wr0); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_release: got ready=%b valid=%b expected 1/0", cmd_ready, rsp_valid);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (bus_wr_enable !== 1'b1 || bus_addr !== 64'h8 || bus_wdata !== 32'h00000BAD) begin
            failures++; $display("[TB] FAIL stall_next_cmd: got wr=%b addr=%h wdata=%h expected 1/8/00000bad", bus_wr_enable, bus_addr, bus_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h00000BAD) begin
            failures++; $display("[TB] FAIL stall_next_rsp: got valid=%b data=%h expected 1/00000bad", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int wr0;
        cmd_op = OP_SET; cmd_addr = 64'h4; cmd_data = 32'h0F; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (bus_rd_enable !== 1'b1) begin failures++; $display("[TB] FAIL abort_in_rd: got rd=%b expected 1", bus_rd_enable); end
        wr0 = wrCount;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus_wr_enable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL abort_state: got wr=%b valid=%b ready=%b expected 0/0/1", bus_wr_enable, rsp_valid, cmd_ready);
        end
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (wrCount != wr0 || gpioRegs[1] !== 32'h30) begin
            failures++; $display("[TB] FAIL abort_no_write: got writes=%0d reg1=%h expected 0/00000030", wrCount - wr0, gpioRegs[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expData[4] = '{32'h11111111, 32'h00000030, 32'h22222222, 32'h33333333};
        logic [31:0] gotData[4];
        int rspCyc[4], accCyc[4];
        int idx, rspCount, rd0, lat, rdd, wrd;
        logic readyNow; logic [31:0] d; logic e;
        applyStimulus(OP_WRITE, 64'h0, 32'h11111111, d, e, lat, rdd, wrd);
        applyStimulus(OP_WRITE, 64'h8, 32'h22222222, d, e, lat, rdd, wrd);
        applyStimulus(OP_WRITE, 64'hC, 32'h33333333, d, e, lat, rdd, wrd);
        idx = 0; rspCount = 0; rd0 = rdCount;
        rsp_ready = 1'b1;
        cmd_op = OP_READ; cmd_addr = 64'h0; cmd_data = 32'h0; cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && rspCount < 4; cyc++) begin
            readyNow = cmd_ready;
            if (rsp_valid) begin
                gotData[rspCount] = rsp_data;
                rspCyc[rspCount] = cyc;
                rspCount++;
            end
            @(posedge clk); #1;
            if (readyNow && cmd_valid && idx < 4) begin
                accCyc[idx] = cyc;
                idx++;
                if (idx < 4) cmd_addr = 64'(idx * 4);
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (rspCount != 4 || rdCount - rd0 != 4) begin
            failures++; $display("[TB] FAIL b2b_count: got rsps=%0d rds=%0d expected 4/4", rspCount, rdCount - rd0);
        end
        for (int i = 0; i < rspCount; i++) begin
            checks++;
            if (gotData[i] !== expData[i]) begin failures++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, gotData[i], expData[i]); end
            if (i > 0 && i < idx) begin
                checks++;
                if (rspCyc[i] - rspCyc[i-1] != 3 || accCyc[i] - accCyc[i-1] != 3) begin
                    failures++; $display("[TB] FAIL b2b_spacing%0d: got rsp=%0d acc=%0d cycles expected 3/3", i, rspCyc[i] - rspCyc[i-1], accCyc[i] - accCyc[i-1]);
                end
            end
        end
        checks++;
        if (overlapCount != 0) begin failures++; $display("[TB] FAIL rd_wr_overlap: got %0d cycles expected 0", overlapCount); end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = OP_READ;
        cmd_addr = '0;
        cmd_data = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_rmw();
        test_errors();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
